// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//
// Instruction-memory request/response bus between the fetch stage and the
// instruction memory.
//
//   req    fetch -> mem   request valid
//   addr   fetch -> mem   word address, stable while req=1 and ack=0
//   ack    mem -> fetch   response valid, same cycle as req or later
//   rdata  mem -> fetch   instruction word, valid while ack=1
//
// Modports:
//   master  used by the fetch stage (drives req/addr)
//   slave   used by the memory (drives ack/rdata)
//
// The instruction width comes from the ISIZE macro (32 unless the build
// defines it).
// -----------------------------------------------------------------------------
`ifndef ISIZE
`define ISIZE 32
`endif

interface fetch_stage_if #(
    parameter int ASIZE = 32
) ();
    logic               req;
    logic [ASIZE-1:0]   addr;
    logic               ack;
    logic [`ISIZE-1:0]  rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the three-stage pipeline. It keeps the program
// counter, issues one word request at a time to instruction memory, parks one
// instruction in a hold buffer when the pipeline stalls, and handles branch
// redirects, including discarding a response that is still in flight.
// All outputs are registered and feed the IF/ID register directly.
//
// Parameters:
//   ASIZE     instruction address width
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous, active-low reset
//   stall        downstream hazard stall; inst/inst_valid/pc_out hold while high
//   redirect     branch taken / flush; restart fetch at redirect_pc
//   redirect_pc  redirect target address
//   imem         instruction memory bus (fetch_stage_if.master)
//   inst         fetched instruction, 0 (bubble) when inst_valid=0
//   inst_valid   inst holds a real instruction
//   pc_out       address of inst
//   misalign     (FETCH_MISALIGN_CHK_EN only) sticky flag, set by any
//                redirect whose target has nonzero bits [1:0]
//
// Build option:
//   FETCH_MISALIGN_CHK_EN  when defined, redirect targets are forced to word
//                          alignment and the misalign port is present.
//
// States:
//   IDLE   after reset; issues the first request on the next edge
//   WAIT   request outstanding; each ack delivers one instruction
//   HOLD   an instruction arrived during a stall and sits in the hold buffer
//   DRAIN  a redirect arrived while a request was in flight; the stale
//          response is awaited and dropped, then fetch restarts at the target
// -----------------------------------------------------------------------------
`ifndef ISIZE
`define ISIZE 32
`endif

module fetch_stage #(
    parameter int               ASIZE    = 32,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ASIZE-1:0]    redirect_pc,
    fetch_stage_if.master       imem,
    output logic [`ISIZE-1:0]   inst,
    output logic                inst_valid,
    output logic [ASIZE-1:0]    pc_out
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                misalign
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [ASIZE-1:0] WORD_STEP = ASIZE'(4);

    // Registered state
    logic [1:0]         state;
    logic               req_q;
    logic [ASIZE-1:0]   addr_q;
    logic [`ISIZE-1:0]  inst_q;
    logic               valid_q;
    logic [ASIZE-1:0]   pc_q;
    logic [`ISIZE-1:0]  hold_inst;
    logic [ASIZE-1:0]   hold_pc;
    logic [ASIZE-1:0]   drain_pc;
    logic               misalign_q;

    // Next-state values
    logic [1:0]         state_d;
    logic               req_d;
    logic [ASIZE-1:0]   addr_d;
    logic [`ISIZE-1:0]  inst_d;
    logic               valid_d;
    logic [ASIZE-1:0]   pc_d;
    logic [`ISIZE-1:0]  hold_inst_d;
    logic [ASIZE-1:0]   hold_pc_d;
    logic [ASIZE-1:0]   drain_pc_d;
    logic               misalign_d;

    logic [ASIZE-1:0]   target;

    // Redirect target as actually used for fetching.
    always_comb begin
        target = redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        target[1:0] = 2'b00;
`endif
    end

    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves it unassigned; a missing default here infers a latch.
        state_d     = state;
        req_d       = req_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst;
        hold_pc_d   = hold_pc;
        drain_pc_d  = drain_pc;
        misalign_d  = misalign_q;

`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
`endif

        // Without a stall the output register shows a bubble unless a new
        // instruction lands this cycle (assigned further down). A redirect
        // always flushes the output, even while stalled.
        if (!stall || redirect) begin
            inst_d  = '0;
            valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                req_d   = 1'b1;
                state_d = WAIT;
                if (redirect) begin
                    addr_d = target;
                end
            end

            WAIT: begin
                if (redirect) begin
                    if (imem.ack) begin
                        // Response arrives with the redirect: drop it and
                        // issue the target request straight away.
                        addr_d = target;
                    end else begin
                        // The memory still owes us the old word; addr/req
                        // must stay put until it shows up.
                        drain_pc_d = target;
                        state_d    = DRAIN;
                    end
                end else if (imem.ack) begin
                    if (!stall) begin
                        inst_d  = imem.rdata;
                        valid_d = 1'b1;
                        pc_d    = addr_q;
                        addr_d  = addr_q + WORD_STEP;
                    end else begin
                        // Pipeline cannot take it: park it and stop fetching.
                        hold_inst_d = imem.rdata;
                        hold_pc_d   = addr_q;
                        req_d       = 1'b0;
                        state_d     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end else if (!stall) begin
                    inst_d  = hold_inst;
                    valid_d = 1'b1;
                    pc_d    = hold_pc;
                    addr_d  = hold_pc + WORD_STEP;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    if (imem.ack) begin
                        addr_d  = target;
                        state_d = WAIT;
                    end else begin
                        drain_pc_d = target;
                    end
                end else if (imem.ack) begin
                    addr_d  = drain_pc;
                    state_d = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            inst_q     <= '0;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            hold_inst  <= '0;
            hold_pc    <= '0;
            drain_pc   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state      <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            hold_inst  <= hold_inst_d;
            hold_pc    <= hold_pc_d;
            drain_pc   <= drain_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc_out     = pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign = misalign_q;
`else
    // The sticky flag only exists with the alignment check built in.
    logic unused_misalign;
    assign unused_misalign = misalign_q ^ misalign_d;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. A behavioural memory answers each
// request after a programmable number of cycles with word_of(addr). The
// stimulus pushes the expected (inst, pc) stream into a queue; a monitor pops
// and compares on every new delivery and checks that bubbles read as 0.
// -----------------------------------------------------------------------------
`ifndef ISIZE
`define ISIZE 32
`endif

module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    fetch_stage_if #(.ASIZE(32)) imem_bus ();

    fetch_stage #(
        .ASIZE    (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: ack after 'lat' cycles of an unanswered request.
    int unsigned lat = 0;
    int unsigned wait_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst)                               wait_cnt <= 0;
        else if (imem_bus.req && !imem_bus.ack) wait_cnt <= wait_cnt + 1;
        else                                    wait_cnt <= 0;
    end

    assign imem_bus.ack   = imem_bus.req && (wait_cnt >= lat);
    assign imem_bus.rdata = word_of(imem_bus.addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.inst = word_of(pc);
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: a delivery is new when the edge saw neither stall nor redirect.
    initial begin : monitor
        logic stall_s;
        logic redir_s;
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_s = stall;
            redir_s = redirect;
            rst_s   = rst;
            #1;
            if (rst_s && rst) begin
                if (inst_valid && !stall_s && !redir_s) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_delivery: got inst=%h pc=%h expected none at %0t",
                                 inst, pc_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver_inst", 64'(inst), 64'(e.inst));
                        check("deliver_pc", 64'(pc_out), 64'(e.pc));
                    end
                end
                if (!inst_valid) check("bubble_inst_zero", 64'(inst), 64'h0);
            end
        end
    end

    // Bounded wait for all expected deliveries; returns on a negedge.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_all_delivered"}, 64'(exp_q.size()), 64'h0);
    endtask

    // Asserts reset immediately, checks reset values, returns on a negedge
    // with rst still low.
    task automatic do_reset();
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check("rst_req", 64'(imem_bus.req), 64'h0);
        check("rst_addr", 64'(imem_bus.addr), 64'h0);
        check("rst_inst", 64'(inst), 64'h0);
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_pc", 64'(pc_out), 64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("rst_misalign", 64'(misalign), 64'h0);
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [8:0]  vpat;
        logic [31:0] tgt;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2;

        // 1: zero-wait memory, first valid on 2nd edge, then one per cycle.
        do_reset();
        lat = 0;
        push(32'h0); push(32'h4); push(32'h8);
        rst = 1'b1;
        @(posedge clk); #2;
        check("zw_e1_valid", 64'(inst_valid), 64'h0);
        check("zw_e1_req", 64'(imem_bus.req), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("zw_consecutive_valid", 64'(inst_valid), 64'h1);
        end
        wait_drain("zero_wait");

        // 2: three-cycle memory, one instruction per four cycles.
        do_reset();
        lat = 3;
        push(32'h0); push(32'h4);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #2;
            vpat[i] = inst_valid;
            if (i < 4) begin
                check("lat3_addr_stable", 64'(imem_bus.addr), 64'h0);
                check("lat3_req_held", 64'(imem_bus.req), 64'h1);
            end
        end
        check("lat3_valid_pattern", 64'(vpat), 64'(9'b1_0001_0000));
        wait_drain("lat3");

        // 3: stall over the ack of 0x8 for five edges.
        do_reset();
        lat = 0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("stall_inst_held", 64'(inst), 64'(word_of(32'h4)));
            check("stall_pc_held", 64'(pc_out), 64'h4);
            check("stall_valid_held", 64'(inst_valid), 64'h1);
            check("stall_req_dropped", 64'(imem_bus.req), 64'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        wait_drain("stall");

        // 4: redirect to 0x100 while the 0x4 response is still pending.
        do_reset();
        lat = 3;
        push(32'h0); push(32'h100);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(posedge clk); #2;
        check("redir_inst_flushed", 64'(inst), 64'h0);
        check("redir_valid_flushed", 64'(inst_valid), 64'h0);
        check("redir_drain_addr_kept", 64'(imem_bus.addr), 64'h4);
        check("redir_drain_req_kept", 64'(imem_bus.req), 64'h1);
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #2;
        check("redir_new_addr", 64'(imem_bus.addr), 64'h100);
        wait_drain("redirect_drain");

        // 5a: redirect together with stall while in HOLD drops the buffer.
        do_reset();
        lat = 0;
        push(32'h0); push(32'h40); push(32'h44);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_req_low", 64'(imem_bus.req), 64'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk); #2;
        check("hold_redir_valid", 64'(inst_valid), 64'h0);
        check("hold_redir_addr", 64'(imem_bus.addr), 64'h40);
        check("hold_redir_req", 64'(imem_bus.req), 64'h1);
        @(negedge clk);
        stall    = 1'b0;
        redirect = 1'b0;
        wait_drain("hold_redirect");

        // 5b: two redirects in DRAIN, the later target wins.
        do_reset();
        lat = 3;
        push(32'h0); push(32'h300);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("drain_twice_addr", 64'(imem_bus.addr), 64'h300);
        wait_drain("drain_twice");

        // 6: zero-wait redirect latency (and alignment check when built in).
        do_reset();
        lat = 0;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = 32'h100;
`else
        tgt = 32'h104;
`endif
        push(32'h0); push(tgt);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        redirect = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
        redirect_pc = 32'h103;
`else
        redirect_pc = 32'h104;
`endif
        @(posedge clk); #2;
        check("zw_redir_addr", 64'(imem_bus.addr), 64'(tgt));
        check("zw_redir_valid", 64'(inst_valid), 64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_set", 64'(misalign), 64'h1);
`endif
        @(negedge clk);
        redirect = 1'b0;
        @(posedge clk); #2;
        check("zw_redir_2edge_valid", 64'(inst_valid), 64'h1);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_sticky", 64'(misalign), 64'h1);
`endif
        wait_drain("zw_redirect");

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the three-stage pipeline; it produces the instruction stream that the IF/ID pipeline register samples. Keeps the program counter, issues word requests to instruction memory over a req/ack handshake, and buffers one instruction when the pipeline stalls. Handles branch redirect/flush, including discarding an in-flight memory response. Outputs are registered and drive the IF/ID register's instruction input directly.

## Interface
- ASIZE, 32, instruction address width in bits
- RESET_PC, 0, first fetch address after reset
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  downstream hazard stall; outputs must hold while high
- redirect  input  1  branch taken/flush; restart fetch at redirect_pc
- redirect_pc  input  ASIZE  redirect target address
- imem_req  output  1  memory request valid
- imem_addr  output  ASIZE  memory word address; stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  memory response valid, same cycle as or later than req
- imem_rdata  input  `ISIZE  instruction word, valid when imem_ack=1
- inst  output  `ISIZE  fetched instruction to IF/ID; 0 (bubble) when not valid
- inst_valid  output  1  inst holds a real instruction
- pc_out  output  ASIZE  address of inst

## Operation
- States: IDLE, WAIT, HOLD, DRAIN.
- Reset (rst=0, asynchronous): state IDLE, imem_req=0, imem_addr=RESET_PC, inst=0, inst_valid=0, pc_out=RESET_PC, hold buffer=0, drain target=RESET_PC.
- IDLE: next edge -> WAIT, imem_req=1 at imem_addr.
- WAIT, ack=0: hold req and addr; stall has no effect.
- WAIT, ack=1, stall=0: inst<=imem_rdata, inst_valid<=1, pc_out<=imem_addr, imem_addr<=imem_addr+4 (wraps modulo 2^ASIZE); stay WAIT, req stays 1 (back-to-back).
- WAIT, ack=1, stall=1: imem_rdata and address captured in hold buffer; inst/inst_valid/pc_out unchanged; req<=0; -> HOLD.
- HOLD: while stall=1 hold everything. On stall=0: present buffer on inst/pc_out with inst_valid=1, imem_addr<=buffered address+4, req<=1, -> WAIT.
- Any state, stall=1 with no new instruction: inst/inst_valid/pc_out hold.
- Redirect (priority over stall and ack): inst<=0, inst_valid<=0.
  - WAIT with ack=1, HOLD, IDLE: response/buffer discarded; imem_addr<=redirect_pc, req<=1, -> WAIT.
  - WAIT with ack=0: request in flight; latch redirect_pc as drain target, keep req/addr, -> DRAIN.
- DRAIN: req held at old address; on ack, data discarded, imem_addr<=drain target, -> WAIT. A further redirect in DRAIN overwrites the drain target.
- Reset mid-transaction: asynchronous return to reset values; memory must tolerate an abandoned request.

## Timing
- Zero-wait memory (ack tied to req): first inst_valid=1 two edges after rst deasserts (IDLE->WAIT, then capture); one instruction per cycle thereafter.
- N-cycle memory: one instruction per N+1 cycles; no speculative second request.
- Redirect to first valid target instruction: 2 edges with zero-wait memory; plus remaining in-flight latency in DRAIN.
- Stall release: buffered instruction appears on the edge stall is sampled low; no instruction lost or duplicated.

## Configuration
- FETCH_MISALIGN_CHK_EN defined: redirect_pc bits [1:0] forced to 0 before use; additional output misalign (1 bit, reset 0) sets sticky on any redirect with nonzero low bits, cleared only by reset.
- Not defined: redirect_pc used unmodified; no misalign port.

## Test plan
- Reset, zero-wait memory returning word = address: inst_valid rises on 2nd edge after release; inst/pc_out sequence 0x0,0x4,0x8 on consecutive cycles.
- ack delayed 3 cycles: imem_addr stable during wait; inst_valid pulses once per 4 cycles; pc_out 0x0,0x4.
- stall high 5 cycles coinciding with ack of 0x8: inst stays 0x4 instruction; after release inst=0x8 word, next 0xC; no gap or duplicate.
- redirect to 0x100 with ack pending 2 more cycles: inst=0, inst_valid=0 next edge; old response discarded; next request addr 0x100, pc_out=0x100 on delivery.
- redirect and stall both high while in HOLD: buffer dropped, fetch from target; redirect twice in DRAIN (0x200 then 0x300): fetch resumes at 0x300.
- With FETCH_MISALIGN_CHK_EN, redirect_pc=0x103: fetch at 0x100, misalign=1 until reset.
